// File: rtl/ff_emu_pkg.sv
// Shared types for the flip-flop emulation bank: operating modes, control FSM states
// and the per-mode JK excitation mapping.
package ff_emu_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } state_t;

  // Returns {J, K}. In SR mode an S=R=1 bit maps to J=K=0, so the cell simply holds.
  function automatic logic [1:0] excite(input mode_t m, input logic a, input logic b);
    logic [1:0] jk;
    case (m)
      MODE_D:  jk = {a, ~a};
      MODE_T:  jk = {a, a};
      MODE_SR: jk = {a & ~b, b & ~a};
      default: jk = {a, b};
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset and a load enable.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= 1'b0;
    else if (en)
      q <= (j & ~q) | (~k & q);
  end

endmodule

// File: rtl/ff_emu_jk_bank.sv
// Bank of JK cells emulating D/T/SR/JK flip-flops, with a two-state mode-switch FSM.
// Define FF_EMU_ERRCNT_EN to build the saturating illegal-input counter behind err_cnt.
module ff_emu_jk_bank
  import ff_emu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_req,
  input  logic             mode_req_valid,
  output logic             mode_ack,
  output logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] Q,
  output logic             illegal,
  output logic [ERR_W-1:0] err_cnt
);

  state_t state, state_next;
  mode_t  mode_q, mode_pending;
  logic   apply_en, take_req, finish_switch, illegal_now;
  logic [WIDTH-1:0] j_bits, k_bits;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (mode_req_valid) state_next = ST_SWITCH;
      ST_SWITCH: state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  // In RUN, en and a request may coincide: the data is applied under the old mode first.
  always_comb begin
    apply_en      = (state == ST_RUN) && en;
    take_req      = (state == ST_RUN) && mode_req_valid;
    finish_switch = (state == ST_SWITCH);
    illegal_now   = apply_en && (mode_q == MODE_SR) && (|(a & b));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_D;
      mode_pending <= MODE_D;
      mode_ack     <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      mode_ack <= finish_switch;
      illegal  <= illegal_now;
      if (take_req)
        mode_pending <= mode_t'(mode_req);
      if (finish_switch)
        mode_q <= mode_pending;
    end
  end

  assign mode = mode_q;

  always_comb begin
    j_bits = '0;
    k_bits = '0;
    for (int i = 0; i < WIDTH; i++)
      {j_bits[i], k_bits[i]} = excite(mode_q, a[i], b[i]);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (apply_en),
      .j     (j_bits[i]),
      .k     (k_bits[i]),
      .q     (Q[i])
    );
  end

`ifdef FF_EMU_ERRCNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= '0;
    else if (illegal_now && (err_q != {ERR_W{1'b1}}))
      err_q <= err_q + 1'b1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ff_emu_jk_bank.sv
// Self-checking bench for ff_emu_jk_bank: behavioural model compared every cycle,
// plus hand-computed directed checks. Expects err_cnt to count only with FF_EMU_ERRCNT_EN.
module tb_ff_emu_jk_bank;

  localparam int WIDTH   = 4;
  localparam int ERR_W   = 2;
  localparam int CNT_MAX = (1 << ERR_W) - 1;
`ifdef FF_EMU_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [31:0] ERR_ONE = CNT_EN ? 32'd1 : 32'd0;
  localparam logic [31:0] ERR_SAT = CNT_EN ? 32'd3 : 32'd0;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode_req = 2'b00;
  logic             mode_req_valid = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             mode_ack;
  logic [1:0]       mode;
  logic [WIDTH-1:0] Q;
  logic             illegal;
  logic [ERR_W-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_emu_jk_bank #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_ack       (mode_ack),
    .mode           (mode),
    .en             (en),
    .a              (a),
    .b              (b),
    .Q              (Q),
    .illegal        (illegal),
    .err_cnt        (err_cnt)
  );

  // Model: per-bit truth tables of each flip-flop type, a pending-switch flag and an error tally.
  logic [WIDTH-1:0] m_q = '0;
  logic [1:0]       m_mode = 2'b00;
  logic [1:0]       m_pend = 2'b00;
  bit               m_busy = 1'b0;
  bit               m_ack = 1'b0;
  bit               m_ill = 1'b0;
  int               m_cnt = 0;
  bit               m_valid = 1'b0;

  function automatic logic [WIDTH-1:0] nextBank(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] ai,
                                                input logic [WIDTH-1:0] bi,
                                                input logic [1:0] md);
    logic [WIDTH-1:0] n;
    n = q;
    for (int i = 0; i < WIDTH; i++) begin
      case (md)
        2'b00: n[i] = ai[i];
        2'b01: n[i] = q[i] ^ ai[i];
        2'b10: n[i] = (ai[i] && !bi[i]) ? 1'b1 : ((bi[i] && !ai[i]) ? 1'b0 : q[i]);
        default: begin
          case ({ai[i], bi[i]})
            2'b00: n[i] = q[i];
            2'b01: n[i] = 1'b0;
            2'b10: n[i] = 1'b1;
            default: n[i] = ~q[i];
          endcase
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      m_mode <= 2'b00;
      m_busy <= 1'b0;
      m_ack <= 1'b0;
      m_ill <= 1'b0;
      m_cnt <= 0;
      m_valid <= 1'b1;
    end else if (m_busy) begin
      m_mode <= m_pend;
      m_ack <= 1'b1;
      m_ill <= 1'b0;
      m_busy <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      m_ill <= en && (m_mode == 2'b10) && (|(a & b));
      if (en)
        m_q <= nextBank(m_q, a, b, m_mode);
      if (en && (m_mode == 2'b10) && (|(a & b)) && CNT_EN && (m_cnt < CNT_MAX))
        m_cnt <= m_cnt + 1;
      if (mode_req_valid) begin
        m_pend <= mode_req;
        m_busy <= 1'b1;
      end
    end
  end

  task automatic compareOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      compareOne("model_Q", 32'(Q), 32'(m_q));
      compareOne("model_mode", 32'(mode), 32'(m_mode));
      compareOne("model_ack", 32'(mode_ack), 32'(m_ack));
      compareOne("model_illegal", 32'(illegal), 32'(m_ill));
      compareOne("model_err_cnt", 32'(err_cnt), 32'(m_cnt));
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] q_exp, input logic [1:0] mode_exp,
                             input logic ack_exp, input logic ill_exp, input logic [31:0] err_exp);
    compareOne({name, "_Q"}, 32'(Q), 32'(q_exp));
    compareOne({name, "_mode"}, 32'(mode), 32'(mode_exp));
    compareOne({name, "_ack"}, 32'(mode_ack), 32'(ack_exp));
    compareOne({name, "_illegal"}, 32'(illegal), 32'(ill_exp));
    compareOne({name, "_err_cnt"}, 32'(err_cnt), err_exp);
  endtask

  // Drives one cycle of inputs at a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input logic en_i, input logic [3:0] a_i, input logic [3:0] b_i,
                               input logic mrv_i, input logic [1:0] mreq_i);
    en = en_i;
    a = a_i;
    b = b_i;
    mode_req_valid = mrv_i;
    mode_req = mreq_i;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1, 2'b11);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("reset", 4'b0000, 2'b00, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;

    applyStimulus(1'b1, 4'b1010, 4'b0000, 1'b0, 2'b00);
    checkOutput("d_load", 4'b1010, 2'b00, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b0, 2'b00);
    checkOutput("d_hold", 4'b1010, 2'b00, 1'b0, 1'b0, 32'd0);

    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b01);
    checkOutput("t_req_n1", 4'b1010, 2'b00, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("t_ack_n2", 4'b1010, 2'b01, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b1010, 4'b0000, 1'b0, 2'b00);
    checkOutput("t_clear", 4'b0000, 2'b01, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 1'b0, 2'b00);
    checkOutput("t_tog1", 4'b0101, 2'b01, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 1'b0, 2'b00);
    checkOutput("t_tog2", 4'b0000, 2'b01, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 1'b0, 2'b00);
    checkOutput("t_tog3", 4'b0101, 2'b01, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b0101, 4'b0000, 1'b0, 2'b00);

    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b10);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("sr_ack", 4'b0000, 2'b10, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b0011, 4'b0110, 1'b0, 2'b00);
    checkOutput("sr_illegal", 4'b0001, 2'b10, 1'b0, 1'b1, ERR_ONE);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("sr_quiet", 4'b0001, 2'b10, 1'b0, 1'b0, ERR_ONE);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 4'b0011, 4'b0110, 1'b0, 2'b00);
    checkOutput("sr_sat", 4'b0001, 2'b10, 1'b0, 1'b1, ERR_SAT);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("sr_sat_hold", 4'b0001, 2'b10, 1'b0, 1'b0, ERR_SAT);

    applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b1, 2'b11);
    checkOutput("en_and_req", 4'b1001, 2'b10, 1'b0, 1'b0, ERR_SAT);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1, 2'b00);
    checkOutput("switch_hold", 4'b1001, 2'b11, 1'b1, 1'b0, ERR_SAT);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("no_second_ack1", 4'b1001, 2'b11, 1'b0, 1'b0, ERR_SAT);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("no_second_ack2", 4'b1001, 2'b11, 1'b0, 1'b0, ERR_SAT);

    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b11);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("same_mode_ack", 4'b1001, 2'b11, 1'b1, 1'b0, ERR_SAT);
    applyStimulus(1'b1, 4'b0110, 4'b1000, 1'b0, 2'b00);
    checkOutput("jk_mix", 4'b0111, 2'b11, 1'b0, 1'b0, ERR_SAT);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 2'b00);
    checkOutput("jk_toggle", 4'b1000, 2'b11, 1'b0, 1'b0, ERR_SAT);

    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b01);
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
    checkOutput("abort_reset", 4'b0000, 2'b00, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00);
      checkOutput("abort_no_ack", 4'b0000, 2'b00, 1'b0, 1'b0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ff_emu_jk_bank.md
FF_EMU_JK_BANK -- requirements
Module: ff_emu_jk_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of emulated flip-flop bits.
REQ-002 SHALL have parameter ERR_W, default 8, width of the illegal-input counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mode_req  input  2  requested mode: 00 D, 01 T, 10 SR, 11 JK.
REQ-006 SHALL have port mode_req_valid  input  1  mode-change request strobe.
REQ-007 SHALL have port mode_ack  output  1  one-cycle pulse when the new mode takes effect.
REQ-008 SHALL have port mode  output  2  current active mode.
REQ-009 SHALL have port en  input  1  apply a/b this cycle.
REQ-010 SHALL have port a  input  WIDTH  D / T / S / J per bit.
REQ-011 SHALL have port b  input  WIDTH  R / K per bit; ignored in D and T modes.
REQ-012 SHALL have port Q  output  WIDTH  flip-flop bank state.
REQ-013 SHALL have port illegal  output  1  registered pulse: SR mode, en=1, (a & b) != 0.
REQ-014 SHALL have port err_cnt  output  ERR_W  count of illegal cycles.

Function
REQ-015 Each bit SHALL be a JK cell: Q_next = (J & ~Q) | (~K & Q).
REQ-016 Excitation mapping SHALL be: D: J=a, K=~a; T: J=a, K=a; SR: J=a&~b, K=b&~a; JK: J=a, K=b.
REQ-017 SR with S=R=1 on a bit SHALL hold that bit; other bits update normally.
REQ-018 en=1 in cycle N SHALL update Q at the end of cycle N; en=0 SHALL hold Q.
REQ-019 Control FSM SHALL have states RUN and SWITCH.
REQ-020 In RUN, sampled mode_req_valid=1 SHALL latch mode_req and go to SWITCH.
REQ-021 In SWITCH, Q SHALL hold, en SHALL be ignored, and mode_req_valid SHALL be ignored (not queued).
REQ-022 Leaving SWITCH SHALL load mode with the latched value, pulse mode_ack for exactly one cycle (request in cycle N -> mode and ack visible in cycle N+2), and return to RUN.
REQ-023 en and mode_req_valid both high in RUN SHALL apply a/b under the old mode and then start the switch.
REQ-024 A request for the current mode SHALL still take the full SWITCH path and pulse mode_ack.
REQ-025 illegal SHALL assert in cycle N+1 for an offending cycle N, once per cycle regardless of bit count.
REQ-026 err_cnt SHALL increment by 1 per illegal cycle and saturate at 2^ERR_W-1.

Reset
REQ-027 reset SHALL force Q=0, mode=00 (D), state RUN, mode_ack=0, illegal=0, err_cnt=0.
REQ-028 reset SHALL take priority over all other inputs; reset during SWITCH SHALL abort the switch with no mode_ack and mode=00.

Configuration
REQ-029 Macro FF_EMU_ERRCNT_EN defined SHALL instantiate the saturating counter of REQ-026.
REQ-030 Without FF_EMU_ERRCNT_EN, err_cnt SHALL be constant 0 with no counter flops; illegal SHALL remain functional.

Structure
REQ-031 Package ff_emu_pkg SHALL hold the mode enum (MODE_D, MODE_T, MODE_SR, MODE_JK) and the FSM state enum.
REQ-032 Sub-module jk_cell (1-bit JK flip-flop with synchronous reset) SHALL be instantiated WIDTH times.

Verification (WIDTH=4)
REQ-033 Reset, D mode, en=1, a=1010 -> Q=1010 next cycle, mode=00.
REQ-034 mode_req=01 pulsed in cycle N -> mode_ack=1 and mode=01 only in cycle N+2; then en=1, a=0101 for 3 cycles from Q=0000 -> Q=0101, 0000, 0101.
REQ-035 SR mode, Q=0000, a=0011, b=0110 -> Q=0001, illegal=1 next cycle, err_cnt=1.
REQ-036 ERR_W=2, 5 consecutive illegal SR cycles -> err_cnt=3, held; without FF_EMU_ERRCNT_EN -> err_cnt=0.
REQ-037 en=1, a=1111 during SWITCH -> Q unchanged; second mode_req_valid during SWITCH -> no second ack.
REQ-038 reset asserted in the SWITCH cycle -> Q=0000, mode=00, mode_ack never asserts.
